// File: rtl/lif_step_scheduler_if.sv
// Control/monitor bundle between the tt_um I/O decode (master) and the LIF step scheduler (slave).
interface lif_step_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8
);
  localparam int AW = $clog2(N_NEURONS);

  logic                 step_start;
  logic [W-1:0]         threshold;
  logic                 cur_we;
  logic [AW-1:0]        cur_addr;
  logic [W-1:0]         cur_data;
  logic [AW-1:0]        mon_sel;
  logic [W-1:0]         mon_v;
  logic                 busy;
  logic                 step_done;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 overrun;

  modport master (
    output step_start, threshold, cur_we, cur_addr, cur_data, mon_sel,
    input  mon_v, busy, step_done, spike_vec, overrun
  );

  modport slave (
    input  step_start, threshold, cur_we, cur_addr, cur_data, mon_sel,
    output mon_v, busy, step_done, spike_vec, overrun
  );
endinterface

// File: rtl/lif_step_scheduler.sv
// Shares one leaky-integrate-and-fire update datapath across N_NEURONS virtual neurons,
// walking LOAD/COMMIT per neuron on every accepted timestep.
module lif_step_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int W            = 8,
  parameter int LEAK_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                clk,
  input  logic                rst,
  lif_step_scheduler_if.slave bus
);
  localparam int AW = $clog2(N_NEURONS);
  localparam int RW = 4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [AW-1:0]        r_idx;
  logic [W-1:0]         r_v    [N_NEURONS];
  logic [RW-1:0]        r_ref  [N_NEURONS];
  logic [W-1:0]         r_cur  [N_NEURONS];
  logic [W-1:0]         r_snap [N_NEURONS];
  logic [W-1:0]         r_thr;
  logic [W-1:0]         r_v_ld;
  logic [W-1:0]         r_i_ld;
  logic [RW-1:0]        r_ref_ld;
  logic [N_NEURONS-1:0] r_work;
  logic [N_NEURONS-1:0] r_spike_vec;
  logic                 r_overrun;
  logic [W-1:0]         r_mon_v;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_step_done;
  logic                 w_last;
  logic [W-1:0]         w_leaked;
  logic [W:0]           w_sum;
  logic [W-1:0]         w_sat;
  logic                 w_fire;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_step_done = (r_state == S_DONE);
    case (r_state)
      S_IDLE:   if (bus.step_start) begin
                  w_next   = S_LOAD;
                  w_accept = 1'b1;
                end
      S_LOAD:   w_next = S_COMMIT;
      S_COMMIT: w_next = w_last ? S_DONE : S_LOAD;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Leak never underflows (v - (v>>k) >= 0); the extra sum bit catches saturation.
  assign w_last   = (r_idx == AW'(N_NEURONS - 1));
  assign w_leaked = r_v_ld - (r_v_ld >> LEAK_SHIFT);
  assign w_sum    = {1'b0, w_leaked} + {1'b0, r_i_ld};
  assign w_sat    = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
  assign w_fire   = (r_ref_ld == '0) && (w_sat >= r_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-neuron arrays are tiny flop banks, so they are cleared on reset like any other state.
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]    <= '0;
        r_ref[i]  <= '0;
        r_cur[i]  <= '0;
        r_snap[i] <= '0;
      end
      r_idx       <= '0;
      r_thr       <= '0;
      r_v_ld      <= '0;
      r_i_ld      <= '0;
      r_ref_ld    <= '0;
      r_work      <= '0;
      r_spike_vec <= '0;
      r_overrun   <= 1'b0;
      r_mon_v     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every read in this block on pre-edge values.
      if (bus.cur_we) r_cur[bus.cur_addr] <= bus.cur_data;

      // Same-cycle current write is forwarded into the snapshot.
      if (w_accept) begin
        for (int i = 0; i < N_NEURONS; i++)
          r_snap[i] <= (bus.cur_we && bus.cur_addr == AW'(i)) ? bus.cur_data : r_cur[i];
        r_thr  <= bus.threshold;
        r_idx  <= '0;
        r_work <= '0;
      end

      if (r_state == S_LOAD) begin
        r_v_ld   <= r_v[r_idx];
        r_ref_ld <= r_ref[r_idx];
        r_i_ld   <= r_snap[r_idx];
      end

      if (r_state == S_COMMIT) begin
        if (r_ref_ld != '0) begin
          r_v[r_idx]   <= '0;
          r_ref[r_idx] <= r_ref_ld - RW'(1);
        end else if (w_fire) begin
          r_v[r_idx]    <= '0;
          r_ref[r_idx]  <= RW'(REFRAC_STEPS);
          r_work[r_idx] <= 1'b1;
        end else begin
          r_v[r_idx] <= w_sat;
        end
        r_idx <= r_idx + AW'(1);
      end

      if (r_state == S_DONE) r_spike_vec <= r_work;
      if (bus.step_start && w_busy) r_overrun <= 1'b1;
      r_mon_v <= r_v[bus.mon_sel];
    end
  end

  assign bus.mon_v     = r_mon_v;
  assign bus.busy      = w_busy;
  assign bus.step_done = w_step_done;
  assign bus.spike_vec = r_spike_vec;
  assign bus.overrun   = r_overrun;
endmodule
